score_qk: RTL

SCORE_QK -- requirements
Module: score_qk

---
 rtl/score_qk.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/score_qk.sv
`default_nettype none
// ============================================================================
//  Module      : score_qk
//  Description : Attention score engine. For every pair of rows (i, j) of the
//                Q and K matrices it computes the int8 dot product over the
//                head dimension, shifts it arithmetically right by SHIFT,
//                saturates it to int8 and packs eight scores per 64-bit word
//                into the score area of a shared word-addressed memory.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   1   rising-edge clock
//    rst_n     in   1   synchronous active-low reset
//    start     in   1   level request, sampled only while idle
//    done      out  1   high while the finished run is being held
//    write_en  out  1   memory write strobe (one cycle per score word)
//    addr      out  32  memory word address
//    data_in   out  64  write data towards memory
//    data_out  in   64  read data, valid one cycle after addr (write_en=0)
// ----------------------------------------------------------------------------
//  Build option
//    SCORE_ROUND_EN  when defined, 1<<(SHIFT-1) is added before the shift
//                    (round half up); otherwise the shift truncates (floor).
//  SEQ_LEN must be a multiple of 8; SHIFT must be at least 1.
// ============================================================================
module score_qk #(
    parameter int SEQ_LEN   = 16,
    parameter int DIM_WORDS = 4,
    parameter int Q_BASE    = 2048,
    parameter int K_BASE    = 2176,
    parameter int S_BASE    = 2560,
    parameter int SHIFT     = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        done,
    output logic        write_en,
    output logic [31:0] addr,
    output logic [63:0] data_in,
    input  logic [63:0] data_out
);

    localparam int IW = (SEQ_LEN   > 1) ? $clog2(SEQ_LEN)   : 1;
    localparam int WW = (DIM_WORDS > 1) ? $clog2(DIM_WORDS) : 1;

    localparam logic [IW-1:0] c_LAST_ROW  = IW'(SEQ_LEN - 1);
    localparam logic [WW-1:0] c_LAST_WORD = WW'(DIM_WORDS - 1);
    localparam int            c_S_WORDS_PER_ROW = SEQ_LEN / 8;

`ifdef SCORE_ROUND_EN
    localparam logic signed [31:0] c_ROUND = 32'sd1 <<< (SHIFT - 1);
`else
    localparam logic signed [31:0] c_ROUND = 32'sd0;
`endif

    localparam logic signed [31:0] c_SAT_HI = 32'sd127;
    localparam logic signed [31:0] c_SAT_LO = -32'sd128;

    // FSM encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD_Q    = 3'd1;
    localparam logic [2:0] ST_LOAD_K    = 3'd2;
    localparam logic [2:0] ST_MAC_DRAIN = 3'd3;
    localparam logic [2:0] ST_WRITE     = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [IW-1:0]      i_q, i_d;           // Q row index
    logic [IW-1:0]      j_q, j_d;           // K row index
    logic [WW-1:0]      w_q, w_d;           // word index within a row
    logic               rd_vld_q, rd_vld_d; // a read was issued last cycle
    logic               rd_k_q, rd_k_d;     // ... and it targeted a K row
    logic [WW-1:0]      rd_w_q, rd_w_d;     // ... at this word index
    logic signed [31:0] acc_q, acc_d;
    logic [63:0]        score_q, score_d;   // eight packed scores of row i
    logic [63:0]        qbuf_q [DIM_WORDS];

    logic signed [31:0] w_lane_dot;
    logic signed [31:0] w_acc_sum;
    logic signed [31:0] w_rounded;
    logic signed [31:0] w_shifted;
    logic [7:0]         w_score;

    // Dot product of eight signed int8 lanes, sign-extended to 32 bits.
    function automatic logic signed [31:0] f_dot8(input logic [63:0] a,
                                                  input logic [63:0] b);
        logic signed [31:0] sum;
        logic signed [7:0]  la;
        logic signed [7:0]  lb;
        logic signed [15:0] prod;
        sum = '0;
        for (int l = 0; l < 8; l++) begin
            la   = a[8*l +: 8];
            lb   = b[8*l +: 8];
            prod = la * lb;
            sum  = sum + {{16{prod[15]}}, prod};
        end
        return sum;
    endfunction

    // The K word returned this cycle is paired with the Q word of the same
    // index; in MAC_DRAIN this sum already includes the last word of the row.
    always_comb begin
        w_lane_dot = f_dot8(qbuf_q[rd_w_q], data_out);
        w_acc_sum  = acc_q + w_lane_dot;
        w_rounded  = w_acc_sum + c_ROUND;
        w_shifted  = w_rounded >>> SHIFT;
        if (w_shifted > c_SAT_HI) begin
            w_score = 8'h7F;
        end else if (w_shifted < c_SAT_LO) begin
            w_score = 8'h80;
        end else begin
            w_score = w_shifted[7:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        w_d      = w_q;
        rd_vld_d = 1'b0;
        rd_k_d   = 1'b0;
        rd_w_d   = w_q;
        acc_d    = acc_q;
        score_d  = score_q;

        if (rd_vld_q && rd_k_q) begin
            acc_d = w_acc_sum;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD_Q;
                    i_d     = '0;
                    j_d     = '0;
                    w_d     = '0;
                    acc_d   = '0;
                    score_d = '0;
                end
            end
            ST_LOAD_Q: begin
                rd_vld_d = 1'b1;
                acc_d    = '0;
                if (w_q == c_LAST_WORD) begin
                    w_d     = '0;
                    state_d = ST_LOAD_K;
                end else begin
                    w_d = w_q + 1'b1;
                end
            end
            ST_LOAD_K: begin
                rd_vld_d = 1'b1;
                rd_k_d   = 1'b1;
                if (w_q == c_LAST_WORD) begin
                    w_d     = '0;
                    state_d = ST_MAC_DRAIN;
                end else begin
                    w_d = w_q + 1'b1;
                end
            end
            ST_MAC_DRAIN: begin
                score_d[{j_q[2:0], 3'b000} +: 8] = w_score;
                acc_d = '0;
                if (j_q[2:0] == 3'd7) begin
                    state_d = ST_WRITE;
                end else begin
                    j_d     = j_q + 1'b1;
                    state_d = ST_LOAD_K;
                end
            end
            ST_WRITE: begin
                score_d = '0;
                if (j_q == c_LAST_ROW) begin
                    j_d = '0;
                    if (i_q == c_LAST_ROW) begin
                        state_d = ST_DONE;
                    end else begin
                        i_d     = i_q + 1'b1;
                        state_d = ST_LOAD_Q;
                    end
                end else begin
                    j_d     = j_q + 1'b1;
                    state_d = ST_LOAD_K;
                end
            end
            ST_DONE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            i_q      <= '0;
            j_q      <= '0;
            w_q      <= '0;
            rd_vld_q <= 1'b0;
            rd_k_q   <= 1'b0;
            rd_w_q   <= '0;
            acc_q    <= '0;
            score_q  <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            w_q      <= w_d;
            rd_vld_q <= rd_vld_d;
            rd_k_q   <= rd_k_d;
            rd_w_q   <= rd_w_d;
            acc_q    <= acc_d;
            score_q  <= score_d;
        end
    end

    // Q row buffer, filled from the reads issued in LOAD_Q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DIM_WORDS; k++) begin
                qbuf_q[k] <= '0;
            end
        end else if (rd_vld_q && !rd_k_q) begin
            qbuf_q[rd_w_q] <= data_out;
        end
    end

    // Outputs decode directly from registered state, so they are never X
    // once reset has been applied.
    always_comb begin
        done     = (state_q == ST_DONE);
        write_en = (state_q == ST_WRITE);
        data_in  = (state_q == ST_WRITE) ? score_q : 64'd0;
        case (state_q)
            ST_LOAD_Q: addr = 32'(Q_BASE) + 32'(i_q) * 32'(DIM_WORDS) + 32'(w_q);
            ST_LOAD_K: addr = 32'(K_BASE) + 32'(j_q) * 32'(DIM_WORDS) + 32'(w_q);
            ST_WRITE:  addr = 32'(S_BASE) + 32'(i_q) * 32'(c_S_WORDS_PER_ROW)
                              + 32'(j_q >> 3);
            default:   addr = 32'd0;
        endcase
    end

endmodule
`default_nettype wire
